// File: rtl/hilo_pkg.sv
// hilo_pkg: shared op codes, FSM states and default width for the HI/LO unit.
package hilo_pkg;

    localparam int HILO_DATA_W = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_MTHI  = 3'd2,
        OP_MTLO  = 3'd3,
        OP_MADD  = 3'd4,
        OP_MADDU = 3'd5,
        OP_MSUB  = 3'd6,
        OP_MSUBU = 3'd7
    } hilo_op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        ACC      = 2'd2
    } hilo_state_e;

endpackage

// File: rtl/hilo_acc.sv
// hilo_acc: modulo-2^W add/subtract of the HI/LO pair and a captured product.
module hilo_acc #(
    parameter int W = 64
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    output logic [W-1:0] y_o
);

    assign y_o = sub_i ? a_i - b_i : a_i + b_i;

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: MIPS HI/LO registers fed by an external pipelined multiplier.
// Define HILO_MADD_EN to add MADD/MADDU/MSUB/MSUBU through an accumulate state.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int DATA_W = HILO_DATA_W
) (
    input  logic                mul_clk,
    input  logic                resetn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [2:0]          req_op,
    input  logic [DATA_W-1:0]   req_a,
    input  logic [DATA_W-1:0]   req_b,
    input  logic                req_cancel,
    output logic [DATA_W-1:0]   mul_x,
    output logic [DATA_W-1:0]   mul_y,
    output logic                mul_signed,
    input  logic [2*DATA_W-1:0] mul_result,
    input  logic                rd_sel,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_stall,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o
);

    hilo_state_e       state_q;
    logic [DATA_W-1:0] hi_q, lo_q;
    hilo_op_e          op;
    logic              accept;

    assign op         = hilo_op_e'(req_op);
    assign req_ready  = state_q == IDLE;
    assign rd_stall   = !req_ready;
    assign accept     = req_valid && req_ready && !req_cancel;
    // The multiplier samples these every edge; only the accept cycle's values matter.
    assign mul_x      = req_a;
    assign mul_y      = req_b;
    assign mul_signed = op inside {OP_MULT, OP_MADD, OP_MSUB};
    assign rd_data    = rd_sel ? hi_q : lo_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

`ifdef HILO_MADD_EN
    logic [2*DATA_W-1:0] prod_q, acc_sum;
    logic                acc_q, sub_q;

    hilo_acc #(.W(2*DATA_W)) u_acc (
        .a_i   ({hi_q, lo_q}),
        .b_i   (prod_q),
        .sub_i (sub_q),
        .y_o   (acc_sum)
    );
`endif

    always_ff @(posedge mul_clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef HILO_MADD_EN
            prod_q  <= '0;
            acc_q   <= 1'b0;
            sub_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    case (op)
                        OP_MTHI: hi_q <= req_a;
                        OP_MTLO: lo_q <= req_a;
                        OP_MULT, OP_MULTU: begin
                            state_q <= MUL_WAIT;
`ifdef HILO_MADD_EN
                            acc_q   <= 1'b0;
`endif
                        end
`ifdef HILO_MADD_EN
                        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                            state_q <= MUL_WAIT;
                            acc_q   <= 1'b1;
                            sub_q   <= op inside {OP_MSUB, OP_MSUBU};
                        end
`endif
                        default: ;
                    endcase
                end
                MUL_WAIT: begin
                    state_q <= IDLE;
                    if (req_cancel) begin
                    end
`ifdef HILO_MADD_EN
                    else if (acc_q) begin
                        prod_q  <= mul_result;
                        state_q <= ACC;
                    end
`endif
                    else {hi_q, lo_q} <= mul_result;
                end
`ifdef HILO_MADD_EN
                ACC: begin
                    if (!req_cancel) {hi_q, lo_q} <= acc_sum;
                    state_q <= IDLE;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
